// File: rtl/pid_trig_pkg.sv
// Shared constants for the PID window trigger: class indices and register map offsets.
// Latency: none (constants only).
// Backpressure: none.
package pid_trig_pkg;

  // Class indices, also the order of classification priority (lowest index wins)
  localparam int NCLS   = 3;
  localparam int CLS_E  = 0;
  localparam int CLS_MU = 1;
  localparam int CLS_PI = 2;

  // Register offsets from BASE_ADDR
  localparam logic [7:0] REG_CTRL     = 8'd0;
  localparam logic [7:0] REG_MASK     = 8'd1;
  localparam logic [7:0] REG_WIN_E    = 8'd2;
  localparam logic [7:0] REG_WIN_MU   = 8'd3;
  localparam logic [7:0] REG_WIN_PI   = 8'd4;
  localparam logic [7:0] REG_PRESC_E  = 8'd5;
  localparam logic [7:0] REG_PRESC_MU = 8'd6;
  localparam logic [7:0] REG_PRESC_PI = 8'd7;
  localparam logic [7:0] REG_STRETCH  = 8'd8;
  localparam logic [7:0] REG_SCAL_E   = 8'd9;
  localparam logic [7:0] REG_SCAL_MU  = 8'd10;
  localparam logic [7:0] REG_SCAL_PI  = 8'd11;
  localparam logic [7:0] REG_STATUS   = 8'd12;
  localparam logic [7:0] NREGS        = 8'd13;

endpackage

// File: rtl/pid_class_path.sv
// One trigger class: prescaler, output stretcher and saturating 32-bit event scaler.
// Latency: raw_i at cycle m -> trig_o high at m+1 for STRETCH+1 cycles; trig_nxt_o is its next-state.
// Backpressure: none; every raw event is counted, a re-fire reloads the stretch.
module pid_class_path
  import pid_trig_pkg::*;
#(
  parameter int PRESC_W   = 16,
  parameter int STRETCH_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 raw_i,
  input  logic                 presc_clr_i,
  input  logic                 scal_clr_i,
  input  logic [PRESC_W-1:0]   presc_i,
  input  logic [STRETCH_W-1:0] stretch_i,
  output logic                 trig_nxt_o,
  output logic                 trig_o,
  output logic [31:0]          scaler_o
);

  logic [PRESC_W-1:0]   cnt_q, cnt_d;
  logic [STRETCH_W-1:0] str_q, str_d;
  logic                 trig_q, trig_d;
  logic [31:0]          scal_q, scal_d;
  logic                 fire;

  // Next-state: prescale decision, stretch countdown and scaler saturation
  always_comb begin
    fire   = raw_i && (cnt_q == presc_i);
    cnt_d  = cnt_q;
    str_d  = str_q;
    trig_d = 1'b0;
    scal_d = scal_q;
    if (presc_clr_i || fire) begin
      cnt_d = '0;
    end else if (raw_i) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Load cycle plus one cycle per nonzero count gives STRETCH+1 high cycles
    if (fire) begin
      str_d  = stretch_i;
      trig_d = 1'b1;
    end else if (str_q != '0) begin
      str_d  = str_q - 1'b1;
      trig_d = 1'b1;
    end
    if (scal_clr_i) begin
      scal_d = '0;
    end else if (raw_i && (scal_q != 32'hFFFF_FFFF)) begin
      scal_d = scal_q + 32'd1;
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      str_q  <= '0;
      trig_q <= 1'b0;
      scal_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      str_q  <= str_d;
      trig_q <= trig_d;
      scal_q <= scal_d;
    end
  end

  assign trig_nxt_o = trig_d;
  assign trig_o     = trig_q;
  assign scaler_o   = scal_q;

endmodule

// File: rtl/pid_window_trigger.sv
// RF-phase windowed e/mu/pi hit classifier with per-class prescaled, stretched triggers and bus registers.
// Latency: hit rising at cycle n -> trig_* at n+2; bus read/write ack and read data one cycle after strobe.
// Backpressure: none; simultaneous hits in one cycle merge into one event per class.
module pid_window_trigger
  import pid_trig_pkg::*;
#(
  parameter int         NCH       = 32,
  parameter int         TW        = 8,
  parameter int         PRESC_W   = 16,
  parameter int         STRETCH_W = 4,
  parameter logic [7:0] BASE_ADDR = 8'hD0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rf_ref,
  input  logic [NCH-1:0] hit,
  output logic           trig_e,
  output logic           trig_mu,
  output logic           trig_pi,
  output logic           trig_any,
  input  logic [31:0]    DataIn,
  input  logic [7:0]     Address,
  input  logic           Read,
  input  logic           Write,
  output logic [31:0]    DataOut,
  output logic           ack
);

  logic [TW-1:0]        phase_q, phase_d;
  logic [NCH-1:0]       hit_q;
  logic [NCLS-1:0]      raw_q, raw_d, in_win;
  logic [NCLS-1:0]      trig_nxt, trig_vec, presc_clr;
  logic                 trig_any_q, seen_q, seen_d;
  logic [31:0]          dout_q, rdata;
  logic                 ack_q;
  logic                 ctrl_en_q;
  logic [NCH-1:0]       mask_q;
  logic [TW-1:0]        win_lo_q [NCLS];
  logic [TW-1:0]        win_hi_q [NCLS];
  logic [PRESC_W-1:0]   presc_q  [NCLS];
  logic [STRETCH_W-1:0] stretch_q;
  logic [31:0]          scal     [NCLS];
  logic [7:0]           off;
  logic                 in_range, wr_en, rd_en, scal_clr, any_edge;
  logic                 unused_ok;

  assign off      = Address - BASE_ADDR;
  assign in_range = (off < NREGS);
  assign wr_en    = Write && in_range;
  assign rd_en    = Read && in_range;
  assign scal_clr = wr_en && (off == REG_CTRL) && DataIn[1];
  assign presc_clr = {NCLS{wr_en}} & {off == REG_PRESC_PI, off == REG_PRESC_MU, off == REG_PRESC_E};
  assign unused_ok = ^DataIn;

  // Phase, edge detect and classification; all channels share this cycle's timestamp
  always_comb begin
    phase_d = phase_q;
    if (rf_ref) begin
      phase_d = '0;
    end else if (phase_q != '1) begin
      phase_d = phase_q + 1'b1;
    end
    any_edge = |(hit & ~hit_q & mask_q) && ctrl_en_q;
    for (int k = 0; k < NCLS; k++) begin
      in_win[k] = (phase_q >= win_lo_q[k]) && (phase_q <= win_hi_q[k]);
    end
    raw_d[CLS_E]  = any_edge && in_win[CLS_E];
    raw_d[CLS_MU] = any_edge && in_win[CLS_MU] && !in_win[CLS_E];
    raw_d[CLS_PI] = any_edge && in_win[CLS_PI] && !in_win[CLS_E] && !in_win[CLS_MU];
    // A trigger arriving in the read cycle must survive the clear-on-read
    seen_d = trig_any_q || (seen_q && !(rd_en && (off == REG_STATUS)));
  end

  // Datapath registers: phase, hit history, raw class events, status and bus response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q    <= '0;
      hit_q      <= '0;
      raw_q      <= '0;
      trig_any_q <= 1'b0;
      seen_q     <= 1'b0;
      dout_q     <= '0;
      ack_q      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      hit_q      <= hit;
      raw_q      <= raw_d;
      trig_any_q <= |trig_nxt;
      seen_q     <= seen_d;
      dout_q     <= rd_en ? rdata : 32'd0;
      ack_q      <= rd_en || wr_en;
    end
  end

  // Configuration registers; writes are visible the cycle after the strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en_q <= 1'b0;
      mask_q    <= '1;
      stretch_q <= STRETCH_W'(3);
      for (int k = 0; k < NCLS; k++) begin
        win_lo_q[k] <= '1;
        win_hi_q[k] <= '0;
        presc_q[k]  <= '0;
      end
    end else if (wr_en) begin
      case (off)
        REG_CTRL:     ctrl_en_q <= DataIn[0];
        REG_MASK:     mask_q    <= DataIn[NCH-1:0];
        REG_WIN_E:    begin win_lo_q[CLS_E]  <= DataIn[TW-1:0]; win_hi_q[CLS_E]  <= DataIn[16+:TW]; end
        REG_WIN_MU:   begin win_lo_q[CLS_MU] <= DataIn[TW-1:0]; win_hi_q[CLS_MU] <= DataIn[16+:TW]; end
        REG_WIN_PI:   begin win_lo_q[CLS_PI] <= DataIn[TW-1:0]; win_hi_q[CLS_PI] <= DataIn[16+:TW]; end
        REG_PRESC_E:  presc_q[CLS_E]  <= DataIn[PRESC_W-1:0];
        REG_PRESC_MU: presc_q[CLS_MU] <= DataIn[PRESC_W-1:0];
        REG_PRESC_PI: presc_q[CLS_PI] <= DataIn[PRESC_W-1:0];
        REG_STRETCH:  stretch_q <= DataIn[STRETCH_W-1:0];
        default: ;
      endcase
    end
  end

  // Read mux; unused bits read as zero
  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL:     rdata[0] = ctrl_en_q;
      REG_MASK:     rdata[NCH-1:0] = mask_q;
      REG_WIN_E:    begin rdata[TW-1:0] = win_lo_q[CLS_E];  rdata[16+:TW] = win_hi_q[CLS_E];  end
      REG_WIN_MU:   begin rdata[TW-1:0] = win_lo_q[CLS_MU]; rdata[16+:TW] = win_hi_q[CLS_MU]; end
      REG_WIN_PI:   begin rdata[TW-1:0] = win_lo_q[CLS_PI]; rdata[16+:TW] = win_hi_q[CLS_PI]; end
      REG_PRESC_E:  rdata[PRESC_W-1:0] = presc_q[CLS_E];
      REG_PRESC_MU: rdata[PRESC_W-1:0] = presc_q[CLS_MU];
      REG_PRESC_PI: rdata[PRESC_W-1:0] = presc_q[CLS_PI];
      REG_STRETCH:  rdata[STRETCH_W-1:0] = stretch_q;
      REG_SCAL_E:   rdata = scal[CLS_E];
      REG_SCAL_MU:  rdata = scal[CLS_MU];
      REG_SCAL_PI:  rdata = scal[CLS_PI];
      REG_STATUS:   begin rdata[TW-1:0] = phase_q; rdata[16] = seen_q; end
      default: ;
    endcase
  end

  for (genvar k = 0; k < NCLS; k++) begin : g_cls
    pid_class_path #(
      .PRESC_W  (PRESC_W),
      .STRETCH_W(STRETCH_W)
    ) u_path (
      .clk_i      (clk),
      .rst_i      (rst),
      .raw_i      (raw_q[k]),
      .presc_clr_i(presc_clr[k]),
      .scal_clr_i (scal_clr),
      .presc_i    (presc_q[k]),
      .stretch_i  (stretch_q),
      .trig_nxt_o (trig_nxt[k]),
      .trig_o     (trig_vec[k]),
      .scaler_o   (scal[k])
    );
  end

  assign trig_e   = trig_vec[CLS_E];
  assign trig_mu  = trig_vec[CLS_MU];
  assign trig_pi  = trig_vec[CLS_PI];
  assign trig_any = trig_any_q;
  assign DataOut  = dout_q;
  assign ack      = ack_q;

endmodule

// File: tb/tb_pid_window_trigger.sv
// Bench for pid_window_trigger: event-level reference model checked every cycle, plus directed bus checks.
// Latency: model predicts trigger intervals from hit-edge cycle + 2.
// Backpressure: not applicable.
module tb_pid_window_trigger;

  localparam int MAXC  = 8192;
  localparam int MAXPH = 255;
  localparam logic [7:0] A_CTRL = 8'hD0, A_MASK = 8'hD1, A_WE = 8'hD2, A_WMU = 8'hD3, A_WPI = 8'hD4;
  localparam logic [7:0] A_PPI = 8'hD7, A_STR = 8'hD8, A_SE = 8'hD9, A_SMU = 8'hDA, A_SPI = 8'hDB;
  localparam logic [7:0] A_STAT = 8'hDC, A_BAD = 8'hDD;

  logic        clk = 1'b0;
  logic        rst;
  logic        rf_ref;
  logic [31:0] hit;
  logic        trig_e, trig_mu, trig_pi, trig_any;
  logic [31:0] DataIn, DataOut;
  logic [7:0]  Address;
  logic        Read, Write, ack;

  int n_cmp = 0;
  int n_fail = 0;

  pid_window_trigger dut (
    .clk(clk), .rst(rst), .rf_ref(rf_ref), .hit(hit),
    .trig_e(trig_e), .trig_mu(trig_mu), .trig_pi(trig_pi), .trig_any(trig_any),
    .DataIn(DataIn), .Address(Address), .Read(Read), .Write(Write),
    .DataOut(DataOut), .ack(ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_trig[c] = trigger levels the DUT must hold just before clock edge c
  logic [2:0]  exp_trig [MAXC];
  int          cyc = 0;
  int          m_phase, m_stretch, m_en;
  logic [31:0] m_hit_prev, m_mask;
  int          m_lo [3], m_hi [3], m_presc [3], m_cnt [3];
  logic [31:0] m_scal [3];

  always @(posedge clk) begin
    int cls, off;
    if (rst) begin
      m_phase = 0; m_en = 0; m_mask = '1; m_stretch = 3; m_hit_prev = '0;
      for (int k = 0; k < 3; k++) begin
        m_lo[k] = MAXPH; m_hi[k] = 0; m_presc[k] = 0; m_cnt[k] = 0; m_scal[k] = 0;
      end
      for (int c = cyc; c < MAXC; c++) exp_trig[c] = 3'b000;
    end else begin
      if (((hit & ~m_hit_prev & m_mask) != 0) && (m_en != 0)) begin
        cls = -1;
        for (int k = 0; k < 3; k++)
          if (cls < 0 && m_lo[k] <= m_phase && m_phase <= m_hi[k]) cls = k;
        if (cls >= 0) begin
          if (m_scal[cls] != 32'hFFFF_FFFF) m_scal[cls] = m_scal[cls] + 1;
          if (m_cnt[cls] == m_presc[cls]) begin
            m_cnt[cls] = 0;
            for (int d = 0; d <= m_stretch; d++)
              if (cyc + 2 + d < MAXC) exp_trig[cyc + 2 + d][cls] = 1'b1;
          end else begin
            m_cnt[cls] = m_cnt[cls] + 1;
          end
        end
      end
      m_hit_prev = hit;
      m_phase = rf_ref ? 0 : ((m_phase < MAXPH) ? m_phase + 1 : MAXPH);
      if (Write) begin
        off = int'(Address) - 'hD0;
        case (off)
          0: begin m_en = int'(DataIn[0]); if (DataIn[1]) for (int k = 0; k < 3; k++) m_scal[k] = 0; end
          1: m_mask = DataIn;
          2, 3, 4: begin m_lo[off-2] = int'(DataIn[7:0]); m_hi[off-2] = int'(DataIn[23:16]); end
          5, 6, 7: begin m_presc[off-5] = int'(DataIn[15:0]); m_cnt[off-5] = 0; end
          8: m_stretch = int'(DataIn[3:0]);
          default: ;
        endcase
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare and pulse statistics ----------------
  int   hi_cnt [3];
  int   rises [3];
  logic [2:0] prev_trig = 3'b000;

  always @(negedge clk) begin
    logic [2:0] e, a;
    e = (rst || cyc >= MAXC) ? 3'b000 : exp_trig[cyc];
    a = {trig_pi, trig_mu, trig_e};
    chk("trig_e",   {31'd0, a[0]}, {31'd0, e[0]});
    chk("trig_mu",  {31'd0, a[1]}, {31'd0, e[1]});
    chk("trig_pi",  {31'd0, a[2]}, {31'd0, e[2]});
    chk("trig_any", {31'd0, trig_any}, {31'd0, |e});
    for (int k = 0; k < 3; k++) begin
      if (a[k]) hi_cnt[k]++;
      if (a[k] && !prev_trig[k]) rises[k]++;
    end
    prev_trig = a;
  end

  // ---------------- stimulus tasks (all start and end at a falling edge) ----------------
  task automatic clr_stats();
    for (int k = 0; k < 3; k++) begin hi_cnt[k] = 0; rises[k] = 0; end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    Address = a; DataIn = d; Write = 1'b1;
    @(negedge clk);
    Write = 1'b0;
    chk("wr_ack", {31'd0, ack}, 32'd1);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic k);
    Address = a; Read = 1'b1;
    @(negedge clk);
    Read = 1'b0;
    d = DataOut; k = ack;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d; logic k;
    rd(a, d, k);
    chk({nm, "_ack"}, {31'd0, k}, 32'd1);
    chk(nm, d, exp);
  endtask

  task automatic rf_pulse();
    rf_ref = 1'b1;
    @(negedge clk);
    rf_ref = 1'b0;
  endtask

  task automatic hit_pulse(input logic [31:0] m);
    hit = m;
    @(negedge clk);
    hit = '0;
  endtask

  // hit mask m sampled with phase = t
  task automatic hit_at(input int t, input logic [31:0] m);
    rf_pulse();
    repeat (t) @(negedge clk);
    hit_pulse(m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d; logic k;
    rst = 1'b1; rf_ref = 1'b0; hit = '0; DataIn = '0; Address = '0; Read = 1'b0; Write = 1'b0;
    for (int c = 0; c < MAXC; c++) exp_trig[c] = 3'b000;
    clr_stats();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset register values
    rd_chk("rst_ctrl",  A_CTRL, 32'h0);
    rd_chk("rst_mask",  A_MASK, 32'hFFFF_FFFF);
    rd_chk("rst_win_e", A_WE,   32'h0000_00FF);
    rd_chk("rst_str",   A_STR,  32'h3);
    rd_chk("rst_scal_e", A_SE,  32'h0);
    // Live phase four cycles after rf
    rf_pulse();
    repeat (4) @(negedge clk);
    rd_chk("status_phase", A_STAT, 32'h4);

    // Electron window, single hit at phase 15
    wr(A_WE, {16'd20, 16'd10});
    wr(A_CTRL, 32'h1);
    clr_stats();
    hit_at(15, 32'h1 << 5);
    repeat (10) @(negedge clk);
    chk("e_len", hi_cnt[0], 4);
    chk("e_rises", rises[0], 1);
    rd_chk("scal_e_1", A_SE, 32'd1);

    // Overlapping windows: e priority, mu only, and no class
    wr(A_WMU, {16'd30, 16'd15});
    clr_stats();
    hit_at(17, 32'h1 << 2);
    repeat (10) @(negedge clk);
    chk("p17_e", hi_cnt[0], 4);
    chk("p17_mu", hi_cnt[1], 0);
    clr_stats();
    hit_at(25, 32'h1 << 2);
    repeat (10) @(negedge clk);
    chk("p25_mu", hi_cnt[1], 4);
    chk("p25_e", hi_cnt[0], 0);
    clr_stats();
    hit_at(40, 32'h1 << 2);
    repeat (10) @(negedge clk);
    chk("p40_none", hi_cnt[0] + hi_cnt[1] + hi_cnt[2], 0);
    rd_chk("scal_e_2", A_SE, 32'd2);
    rd_chk("scal_mu_1", A_SMU, 32'd1);
    rd_chk("scal_pi_0", A_SPI, 32'd0);

    // Pion prescale by 3: fires on hits 3 and 6
    wr(A_WPI, {16'd60, 16'd50});
    wr(A_PPI, 32'd2);
    clr_stats();
    for (int i = 0; i < 7; i++) begin
      hit_at(55, 32'h1 << 7);
      repeat (5) @(negedge clk);
    end
    chk("pi_rises", rises[2], 2);
    chk("pi_len", hi_cnt[2], 8);
    rd_chk("scal_pi_7", A_SPI, 32'd7);

    // Masked channel, then two channels in one cycle
    wr(A_MASK, 32'hFFFF_FFF7);
    clr_stats();
    hit_at(12, 32'h8);
    repeat (8) @(negedge clk);
    chk("masked", hi_cnt[0], 0);
    rd_chk("scal_e_masked", A_SE, 32'd2);
    clr_stats();
    hit_at(12, 32'h3);
    repeat (8) @(negedge clk);
    chk("dual_rises", rises[0], 1);
    rd_chk("scal_e_dual", A_SE, 32'd3);

    // Saturated phase classifies
    wr(A_WPI, {16'd255, 16'd250});
    wr(A_PPI, 32'd0);
    clr_stats();
    repeat (300) @(negedge clk);
    hit_pulse(32'h1 << 9);
    repeat (8) @(negedge clk);
    chk("sat_pi_len", hi_cnt[2], 4);
    rd_chk("scal_pi_8", A_SPI, 32'd8);

    // Stretch 0 gives one cycle; re-fire extends a stretch of 5
    wr(A_STR, 32'd0);
    clr_stats();
    hit_at(12, 32'h1);
    repeat (6) @(negedge clk);
    chk("str0_len", hi_cnt[0], 1);
    wr(A_STR, 32'd5);
    clr_stats();
    rf_pulse();
    repeat (12) @(negedge clk);
    hit_pulse(32'h1);
    hit_pulse(32'h2);
    repeat (12) @(negedge clk);
    chk("refire_len", hi_cnt[0], 7);
    chk("refire_rises", rises[0], 1);
    rd_chk("scal_e_6", A_SE, 32'd6);
    repeat (20) @(negedge clk);

    // Status clear-on-read, scaler clear, out-of-range
    rd(A_STAT, d, k);
    chk("seen_set", {31'd0, d[16]}, 32'd1);
    rd(A_STAT, d, k);
    chk("seen_clr", {31'd0, d[16]}, 32'd0);
    wr(A_CTRL, 32'h3);
    rd_chk("scal_e_clr", A_SE, 32'd0);
    rd_chk("ctrl_rb", A_CTRL, 32'h1);
    rd(A_BAD, d, k);
    chk("bad_ack", {31'd0, k}, 32'd0);
    chk("bad_data", d, 32'd0);

    // Reset during active stretch
    hit_at(12, 32'h1);
    @(negedge clk);
    chk("pre_rst_trig", {31'd0, trig_e}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_trig_e", {31'd0, trig_e}, 32'd0);
    chk("rst_trig_any", {31'd0, trig_any}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_chk("rst2_ctrl", A_CTRL, 32'h0);
    rd_chk("rst2_str",  A_STR,  32'h3);
    rd_chk("rst2_mask", A_MASK, 32'hFFFF_FFFF);
    rd_chk("rst2_win_e", A_WE,  32'h0000_00FF);
    rd_chk("rst2_scal_e", A_SE, 32'd0);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
